// File: rtl/colour_scan_scheduler.sv
// Shares one TCS3200-style colour sensor between two requesters. Round-robin arbitration
// picks the owner. The scan runs red, blue and green windows, each after a settle gap.
// Edges are counted per window, the dominant colour is classified and a done pulse is returned.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   req[1:0]                     level scan request per requester, held until its done
//   grant[1:0], busy             one-hot sensor owner (00 when idle), busy = grant != 0
//   done                         1-cycle pulse when the owner's scan completes
//   result_colour                00 NONE, 01 RED, 10 GREEN, 11 BLUE (last completed scan)
//   red_cnt, blue_cnt, green_cnt window edge counts of the last completed scan
//   S0..S3                       sensor pins: S0/S1 fixed at 20% scaling, S2/S3 select the filter
//   signal                       sensor frequency output, asynchronous to clk
// Latency from grant rise to done is 3*(SETTLE_CYCLES+WINDOW_CYCLES)+1 cycles.
// A requester that drops req mid-scan aborts the scan silently.
module colour_scan_scheduler #(
  parameter int WINDOW_CYCLES = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 7,
  parameter int MIN_COUNT     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result_colour,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             S3,
  input  logic             signal
);

  localparam int MAX_CYC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W:0]   MIN_C       = (CNT_W+1)'(MIN_COUNT);

  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [1:0] COL_BLUE  = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_CLASSIFY, ST_DONE} state_t;
  typedef enum logic [1:0] {CH_RED, CH_BLUE, CH_GREEN} chan_t;

  state_t           state_q, state_d;
  chan_t            ch_q, ch_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] red_sh_q, red_sh_d, blue_sh_q, blue_sh_d, green_sh_q, green_sh_d;
  logic [CNT_W-1:0] red_q, red_d, blue_q, blue_d, green_q, green_d;
  logic [1:0]       colour_q, colour_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rr_q, rr_d;
  logic             s2_q, s2_d, s3_q, s3_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;

  logic             sig_rise;
  logic             pick_hi;
  logic             owner_live;
  logic [CNT_W-1:0] dom_cnt;
  logic [1:0]       cls_colour;

  // sync3 only holds the previous synchronised level for edge detection
  assign sig_rise   = sync2_q & ~sync3_q;
  // rr_q names the requester preferred on contention (the one not served last)
  assign pick_hi    = (req == 2'b11) ? rr_q : req[1];
  assign owner_live = |(req & grant_q);

  // Ties resolve R > G > B, hence the >= comparisons in that order
  always_comb begin
    if ((red_sh_q >= green_sh_q) && (red_sh_q >= blue_sh_q)) begin
      dom_cnt    = red_sh_q;
      cls_colour = COL_RED;
    end else if (green_sh_q >= blue_sh_q) begin
      dom_cnt    = green_sh_q;
      cls_colour = COL_GREEN;
    end else begin
      dom_cnt    = blue_sh_q;
      cls_colour = COL_BLUE;
    end
    if ({1'b0, dom_cnt} < MIN_C) cls_colour = COL_NONE;
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    timer_d    = timer_q;
    acc_d      = acc_q;
    red_sh_d   = red_sh_q;
    blue_sh_d  = blue_sh_q;
    green_sh_d = green_sh_q;
    red_d      = red_q;
    blue_d     = blue_q;
    green_d    = green_q;
    colour_d   = colour_q;
    grant_d    = grant_q;
    done_d     = 1'b0;
    rr_d       = rr_q;
    s2_d       = s2_q;
    s3_d       = s3_q;
    sync1_d    = signal;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;

    case (state_q)
      ST_IDLE: begin
        s2_d = 1'b0;
        s3_d = 1'b0;
        if (|req) begin
          grant_d = pick_hi ? 2'b10 : 2'b01;
          state_d = ST_SETTLE;
          ch_d    = CH_RED;
          timer_d = SETTLE_LAST;
          acc_d   = '0;
        end
      end
      ST_SETTLE: begin
        acc_d = '0;
        if (timer_q == '0) begin
          state_d = ST_COUNT;
          timer_d = WINDOW_LAST;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_COUNT: begin
        if (sig_rise && (acc_q != CNT_MAX)) acc_d = acc_q + CNT_W'(1);
        if (timer_q == '0) begin
          // Window closes: capture this channel and move the filter on
          state_d = ST_SETTLE;
          timer_d = SETTLE_LAST;
          case (ch_q)
            CH_RED: begin
              red_sh_d = acc_d;
              ch_d     = CH_BLUE;
              s2_d     = 1'b0;
              s3_d     = 1'b1;
            end
            CH_BLUE: begin
              blue_sh_d = acc_d;
              ch_d      = CH_GREEN;
              s2_d      = 1'b1;
              s3_d      = 1'b1;
            end
            default: begin
              green_sh_d = acc_d;
              state_d    = ST_CLASSIFY;
              s2_d       = 1'b0;
              s3_d       = 1'b0;
            end
          endcase
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_CLASSIFY: begin
        // Counts and colour are published together so a reader never sees a mix of scans
        state_d  = ST_DONE;
        done_d   = 1'b1;
        colour_d = cls_colour;
        red_d    = red_sh_q;
        blue_d   = blue_sh_q;
        green_d  = green_sh_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        rr_d    = ~grant_q[1];
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Owner withdrew: drop the scan, keep the last published results and the rr pointer
    if (((state_q == ST_SETTLE) || (state_q == ST_COUNT) || (state_q == ST_CLASSIFY)) &&
        !owner_live) begin
      state_d  = ST_IDLE;
      grant_d  = 2'b00;
      done_d   = 1'b0;
      s2_d     = 1'b0;
      s3_d     = 1'b0;
      colour_d = colour_q;
      red_d    = red_q;
      blue_d   = blue_q;
      green_d  = green_q;
    end

    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= CH_RED;
      timer_q    <= '0;
      acc_q      <= '0;
      red_sh_q   <= '0;
      blue_sh_q  <= '0;
      green_sh_q <= '0;
      red_q      <= '0;
      blue_q     <= '0;
      green_q    <= '0;
      colour_q   <= COL_NONE;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rr_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      timer_q    <= timer_d;
      acc_q      <= acc_d;
      red_sh_q   <= red_sh_d;
      blue_sh_q  <= blue_sh_d;
      green_sh_q <= green_sh_d;
      red_q      <= red_d;
      blue_q     <= blue_d;
      green_q    <= green_d;
      colour_q   <= colour_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rr_q       <= rr_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result_colour = colour_q;
  assign red_cnt       = red_q;
  assign blue_cnt      = blue_q;
  assign green_cnt     = green_q;
  // 20% output scaling regardless of reset
  assign S0            = 1'b1;
  assign S1            = 1'b0;
  assign S2            = s2_q;
  assign S3            = s3_q;

endmodule

// File: tb/tb_colour_scan_scheduler.sv
module tb_colour_scan_scheduler;
  localparam int W   = 100;
  localparam int S   = 10;
  localparam int CW  = 7;
  localparam int MC  = 4;
  localparam int LAT = 3 * (S + W) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, sat_req;
  logic          signal;
  logic [1:0]    grant, result_colour;
  logic          busy, done, S0, S1, S2, S3;
  logic [CW-1:0] red_cnt, blue_cnt, green_cnt;
  logic [1:0]    s_grant, s_colour;
  logic          s_busy, s_done, s_s0, s_s1, s_s2, s_s3;
  logic [4:0]    s_red, s_blue, s_green;

  int checks = 0;
  int errors = 0;
  int hp_r, hp_b, hp_g;   // half-period in clk cycles per filter, 0 = signal held low

  typedef struct {
    logic [1:0] col;
    int         r, b, g, tol;
  } exp_t;
  exp_t sb[$];

  colour_scan_scheduler #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(CW), .MIN_COUNT(MC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .busy(busy), .done(done),
    .result_colour(result_colour), .red_cnt(red_cnt), .blue_cnt(blue_cnt),
    .green_cnt(green_cnt), .S0(S0), .S1(S1), .S2(S2), .S3(S3), .signal(signal));

  // Narrow-counter instance to reach saturation within a 100-cycle window
  colour_scan_scheduler #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(5), .MIN_COUNT(MC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(sat_req), .grant(s_grant), .busy(s_busy), .done(s_done),
    .result_colour(s_colour), .red_cnt(s_red), .blue_cnt(s_blue),
    .green_cnt(s_green), .S0(s_s0), .S1(s_s1), .S2(s_s2), .S3(s_s3), .signal(signal));

  initial forever #5 clk = ~clk;

  // Sensor model: frequency follows the filter the main DUT selects
  initial begin
    int ph;
    int hp;
    signal = 1'b0;
    ph = 0;
    forever begin
      @(negedge clk);
      case ({S2, S3})
        2'b00:   hp = hp_r;
        2'b01:   hp = hp_b;
        2'b11:   hp = hp_g;
        default: hp = 0;
      endcase
      if (hp == 0) begin
        signal = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= hp) begin
          signal = ~signal;
          ph = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int nom, input int tol);
    checks++;
    assert ((obs >= nom - tol) && (obs <= nom + tol)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, nom, tol);
    end
  endtask

  // Called with req already driven at a negedge; expects grant at the next posedge.
  task automatic run_scan(input logic [1:0] gnt, input exp_t e);
    int   n;
    exp_t x;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("grant_rise", 32'(grant), 32'(gnt));
    chk("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < LAT + 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("grant_in_done", 32'(grant), 32'(gnt));
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("colour", 32'(result_colour), 32'(x.col));
      chk_rng("red_cnt", int'(red_cnt), x.r, x.tol);
      chk_rng("blue_cnt", int'(blue_cnt), x.b, x.tol);
      chk_rng("green_cnt", int'(green_cnt), x.g, x.tol);
    end
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("grant_release", 32'(grant), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req = 2'b00; sat_req = 2'b00;
    hp_r = 0; hp_b = 0; hp_g = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_colour", 32'(result_colour), 32'd0);
    chk("rst_red", 32'(red_cnt), 32'd0);
    chk("rst_blue", 32'(blue_cnt), 32'd0);
    chk("rst_green", 32'(green_cnt), 32'd0);
    chk("rst_s0", 32'(S0), 32'd1);
    chk("rst_s1", 32'(S1), 32'd0);
    chk("rst_s2", 32'(S2), 32'd0);
    chk("rst_s3", 32'(S3), 32'd0);

    // Both requesters from reset, signal low: round-robin 01, 10, 01 with NONE results
    @(negedge clk); rst_n = 1'b1; req = 2'b11;
    run_scan(2'b01, '{col: 2'b00, r: 0, b: 0, g: 0, tol: 0});
    run_scan(2'b10, '{col: 2'b00, r: 0, b: 0, g: 0, tol: 0});
    run_scan(2'b01, '{col: 2'b00, r: 0, b: 0, g: 0, tol: 0});
    @(negedge clk); req = 2'b00;

    // Periods 10/20/40 -> red dominant
    hp_r = 5; hp_b = 10; hp_g = 20;
    @(negedge clk); req = 2'b01;
    run_scan(2'b01, '{col: 2'b01, r: 10, b: 5, g: 2, tol: 1});
    @(negedge clk); req = 2'b00;

    // Toggle every cycle: 50 edges per window on 7 bits, saturates on the 5-bit instance
    hp_r = 1; hp_b = 1; hp_g = 1;
    @(negedge clk); req = 2'b01; sat_req = 2'b01;
    run_scan(2'b01, '{col: 2'b01, r: 50, b: 50, g: 50, tol: 0});
    chk("sat_red", 32'(s_red), 32'h1F);
    chk("sat_blue", 32'(s_blue), 32'h1F);
    chk("sat_green", 32'(s_green), 32'h1F);
    chk("sat_colour", 32'(s_colour), 32'd1);
    @(negedge clk); req = 2'b00; sat_req = 2'b00;

    // Owner drops req during the blue window
    hp_r = 5; hp_b = 10; hp_g = 20;
    @(negedge clk); req = 2'b10;
    @(posedge clk); #1;
    chk("abort_grant", 32'(grant), 32'd2);
    repeat (149) @(posedge clk);
    @(negedge clk); req = 2'b00;
    @(posedge clk); #1;
    chk("abort_release", 32'(grant), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_hold_colour", 32'(result_colour), 32'd1);
    chk("abort_hold_red", 32'(red_cnt), 32'd50);
    chk("abort_hold_blue", 32'(blue_cnt), 32'd50);
    chk("abort_hold_green", 32'(green_cnt), 32'd50);

    // Reset in the middle of the green window, then a fresh green-dominant scan
    hp_r = 20; hp_b = 10; hp_g = 5;
    @(negedge clk); req = 2'b01;
    @(posedge clk); #1;
    chk("pre_rst_grant", 32'(grant), 32'd1);
    repeat (280) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_colour", 32'(result_colour), 32'd0);
    chk("arst_red", 32'(red_cnt), 32'd0);
    chk("arst_blue", 32'(blue_cnt), 32'd0);
    chk("arst_green", 32'(green_cnt), 32'd0);
    chk("arst_s0", 32'(S0), 32'd1);
    chk("arst_s1", 32'(S1), 32'd0);
    chk("arst_s2s3", 32'({S2, S3}), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("arst_no_done", 32'(seen), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_scan(2'b01, '{col: 2'b10, r: 2, b: 5, g: 10, tol: 1});
    @(negedge clk); req = 2'b00;

    // Blue dominant
    hp_r = 20; hp_b = 5; hp_g = 20;
    @(negedge clk); req = 2'b01;
    run_scan(2'b01, '{col: 2'b11, r: 2, b: 10, g: 2, tol: 1});
    @(negedge clk); req = 2'b00;

    // All channels below MIN_COUNT -> NONE
    hp_r = 20; hp_b = 20; hp_g = 20;
    @(negedge clk); req = 2'b10;
    run_scan(2'b10, '{col: 2'b00, r: 2, b: 2, g: 2, tol: 1});
    @(negedge clk); req = 2'b00;
    @(posedge clk); #1;
    chk("idle_s2s3", 32'({S2, S3}), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
